hamming_tx_sched: RTL

- Schedules a shared (16,11) extended-Hamming encode/serialize resource between N_REQ requesters.
- Round-robin arbitration; the granted 11-bit word is encoded in parallel at acceptance, then streamed one codeword bit per clock, position 0 first.
- Sits between the per-channel word sources and the serial line/decoder under test.

---
 rtl/hamming_tx_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hamming_tx_sched.sv
// Round-robin scheduler feeding one (16,11) extended-Hamming encoder/serializer.
// Optional HAMMING_TX_ERR_INJ_EN adds a single-shot bit-flip injector (inj_arm/inj_pos).
module hamming_tx_sched #(
  parameter int N_REQ = 2,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [11*N_REQ-1:0]  data_in,
  output logic [N_REQ-1:0]     gnt,
  output logic [IDW-1:0]       gnt_id,
  input  logic                 ser_ready,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 frame_start,
  output logic                 frame_end
`ifdef HAMMING_TX_ERR_INJ_EN
  ,
  input  logic                 inj_arm,
  input  logic [3:0]           inj_pos
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [15:0]      cw, cw_new;
  logic [IDW-1:0]   ptr;
  logic [N_REQ-1:0] gnt_c;
  logic             take;
  logic             found;
  int               sel_idx;

  // Data occupies the non-power-of-two positions; position 0 closes even parity.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    c     = '0;
    c[3]  = d[0];
    c[5]  = d[1];
    c[6]  = d[2];
    c[7]  = d[3];
    c[9]  = d[4];
    c[10] = d[5];
    c[11] = d[6];
    c[12] = d[7];
    c[13] = d[8];
    c[14] = d[9];
    c[15] = d[10];
    c[1]  = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
    c[2]  = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
    c[4]  = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[8]  = ^c[15:9];
    c[0]  = ^c[15:1];
    return c;
  endfunction

`ifdef HAMMING_TX_ERR_INJ_EN
  logic       armed;
  logic [3:0] inj_pos_q;
  logic [3:0] flip_pos;
  logic       do_flip;
`endif

  always_comb begin
    found   = 1'b0;
    sel_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % N_REQ]) begin
        found   = 1'b1;
        sel_idx = (int'(ptr) + k) % N_REQ;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    gnt_c     = '0;
    case (state)
      IDLE: begin
        if (found) take = 1'b1;
      end
      SEND: begin
        if (ser_ready) begin
          if (cnt == 4'd15) begin
            // Final bit handoff: a waiting requester is granted without a gap.
            if (found) take = 1'b1;
            else       state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take) begin
      state_nxt      = SEND;
      cnt_nxt        = 4'd0;
      gnt_c[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    cw_new = encode(data_in[sel_idx*11 +: 11]);
`ifdef HAMMING_TX_ERR_INJ_EN
    do_flip  = inj_arm | armed;
    flip_pos = inj_arm ? inj_pos : inj_pos_q;
    if (do_flip) cw_new[flip_pos] = ~cw_new[flip_pos];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      cw     <= '0;
      ptr    <= '0;
      gnt_id <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        cw     <= cw_new;
        gnt_id <= IDW'(sel_idx);
        ptr    <= IDW'((sel_idx + 1) % N_REQ);
      end
    end
  end

`ifdef HAMMING_TX_ERR_INJ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      inj_pos_q <= 4'd0;
    end else begin
      if (inj_arm) begin
        armed     <= 1'b1;
        inj_pos_q <= inj_pos;
      end
      if (take) armed <= 1'b0;
    end
  end
`endif

  // gnt is combinational; gate it so it reads 0 while reset is held.
  assign gnt         = gnt_c & {N_REQ{rst_n}};
  assign ser_valid   = (state == SEND);
  assign ser_out     = ser_valid & cw[cnt];
  assign frame_start = ser_valid && (cnt == 4'd0);
  assign frame_end   = ser_valid && (cnt == 4'd15);

endmodule
